// File: rtl/mem_access_unit.sv
// Load/store and stack unit behind the EX/MEM register. It shares one memory port
// between reads and writes, so 32-bit stack operations take two memory accesses.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] SP_INIT = 32'h000F_FFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_op,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [2*DATA_W-1:0] in_wdata,
  output logic                out_valid,
  output logic [2*DATA_W-1:0] out_rdata,
  output logic                out_err,
  output logic [ADDR_W-1:0]   sp,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // W0    | first memory access (no strobe for an illegal op)
  // W1    | second access of PUSH32/POP32
  // RESP  | out_valid pulse, SP committed on entry
  typedef enum logic [1:0] {IDLE, W0, W1, RESP} state_t;

  localparam logic [2:0] OP_LDD    = 3'd0;
  localparam logic [2:0] OP_STD    = 3'd1;
  localparam logic [2:0] OP_PUSH   = 3'd2;
  localparam logic [2:0] OP_POP    = 3'd3;
  localparam logic [2:0] OP_PUSH32 = 3'd4;
  localparam logic [2:0] OP_POP32  = 3'd5;

  localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SP_TWO = ADDR_W'(2);

  state_t              state;
  logic [2:0]          op_q;
  logic [DATA_W-1:0]   wdata_lo_q;
  logic [DATA_W-1:0]   rdata_lo_q;
  logic                is_wide;
  logic                is_illegal;

  assign in_ready   = (state == IDLE);
  assign is_wide    = (op_q == OP_PUSH32) || (op_q == OP_POP32);
  assign is_illegal = op_q[2] & op_q[1];

  // SP is only written on the edge into RESP, so every address here sees the
  // stack pointer as it was at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sp         <= SP_INIT;
      out_valid  <= 1'b0;
      out_err    <= 1'b0;
      out_rdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      op_q       <= OP_LDD;
      wdata_lo_q <= '0;
      rdata_lo_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          out_err   <= 1'b0;
          if (in_valid) begin
            op_q       <= in_op;
            wdata_lo_q <= in_wdata[DATA_W-1:0];
            state      <= W0;
            case (in_op)
              OP_LDD: begin
                mem_rd   <= 1'b1;
                mem_addr <= in_addr;
              end
              OP_STD: begin
                mem_wr    <= 1'b1;
                mem_addr  <= in_addr;
                mem_wdata <= in_wdata[DATA_W-1:0];
              end
              OP_PUSH: begin
                mem_wr    <= 1'b1;
                mem_addr  <= sp;
                mem_wdata <= in_wdata[DATA_W-1:0];
              end
              OP_PUSH32: begin
                mem_wr    <= 1'b1;
                mem_addr  <= sp;
                mem_wdata <= in_wdata[2*DATA_W-1:DATA_W];
              end
              OP_POP, OP_POP32: begin
                mem_rd   <= 1'b1;
                mem_addr <= sp + SP_ONE;
              end
              default: ;
            endcase
          end
        end
        W0: begin
          if (is_wide) begin
            state <= W1;
            if (op_q == OP_PUSH32) begin
              mem_addr  <= sp - SP_ONE;
              mem_wdata <= wdata_lo_q;
            end else begin
              rdata_lo_q <= mem_rdata;
              mem_addr   <= sp + SP_TWO;
            end
          end else begin
            state     <= RESP;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            out_valid <= 1'b1;
            out_err   <= is_illegal;
            case (op_q)
              OP_LDD:  out_rdata <= {{DATA_W{1'b0}}, mem_rdata};
              OP_STD:  ;
              OP_PUSH: sp <= sp - SP_ONE;
              OP_POP: begin
                out_rdata <= {{DATA_W{1'b0}}, mem_rdata};
                sp        <= sp + SP_ONE;
              end
              default: out_rdata <= '0;
            endcase
          end
        end
        W1: begin
          state     <= RESP;
          mem_rd    <= 1'b0;
          mem_wr    <= 1'b0;
          out_valid <= 1'b1;
          out_err   <= 1'b0;
          if (op_q == OP_PUSH32) begin
            sp <= sp - SP_TWO;
          end else begin
            sp        <= sp + SP_TWO;
            out_rdata <= {mem_rdata, rdata_lo_q};
          end
        end
        RESP: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a per-request plan of expected cycles is checked every
// cycle, plus literal expectations for the documented scenarios and SP wrap-around.
module tb_mem_access_unit;

  localparam logic [31:0] SP_INIT = 32'h000F_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, out_valid, out_err, mem_rd, mem_wr;
  logic [2:0]  in_op;
  logic [31:0] in_addr, in_wdata, out_rdata, sp, mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic        z_in_ready, z_out_valid, z_out_err, z_mem_rd, z_mem_wr;
  logic [31:0] z_out_rdata, z_sp, z_mem_addr;
  logic [15:0] z_mem_wdata;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(16), .SP_INIT(SP_INIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata), .out_valid(out_valid), .out_rdata(out_rdata),
    .out_err(out_err), .sp(sp), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  // second instance starting at SP=0 to exercise the wrap in both directions
  mem_access_unit #(.ADDR_W(32), .DATA_W(16), .SP_INIT(32'h0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata), .out_valid(z_out_valid), .out_rdata(z_out_rdata),
    .out_err(z_out_err), .sp(z_sp), .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .mem_addr(z_mem_addr),
    .mem_wdata(z_mem_wdata), .mem_rdata(mem_rdata));

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [15:0] wd;
    bit          vld;
    bit          err;
    bit          rdy;
    logic [31:0] rdata;
    logic [31:0] sp;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem_m [logic [31:0]];
  logic [31:0] sp_m = SP_INIT;
  logic [31:0] rdata_m = 32'h0;
  bit          chk_en = 1'b0;
  int          nchk = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          vld_cyc = 0;
  logic [47:0] wr_log[$];
  logic [31:0] z_wr_addr, z_rd_addr;

  logic [2:0]  t_op [6] = '{3'd2, 3'd4, 3'd3, 3'd3, 3'd3, 3'd5};
  logic [31:0] t_wd [6] = '{32'h0000_0001, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rd_mem(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a[15:0] ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e.rd = 0; e.wr = 0; e.addr = 32'h0; e.wd = 16'h0;
    e.vld = 0; e.err = 0; e.rdy = 0;
    e.rdata = rdata_m; e.sp = sp_m;
    return e;
  endfunction

  // Expected cycle-by-cycle behaviour of one request, from the current cycle to RESP.
  task automatic plan(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    exp_t e0, e1, e2, er;
    logic [31:0] nsp, nrd, up1, up2, dn1;
    bit err;
    up1 = sp_m + 32'd1; up2 = sp_m + 32'd2; dn1 = sp_m - 32'd1;
    e0 = blank(); e0.rdy = 1;
    e1 = blank(); e2 = blank();
    nsp = sp_m; nrd = rdata_m; err = 0;
    case (op)
      3'd0: begin e1.rd = 1; e1.addr = a; nrd = {16'h0, rd_mem(a)}; end
      3'd1: begin e1.wr = 1; e1.addr = a; e1.wd = wd[15:0]; mem_m[a] = wd[15:0]; end
      3'd2: begin
        e1.wr = 1; e1.addr = sp_m; e1.wd = wd[15:0]; mem_m[sp_m] = wd[15:0]; nsp = dn1;
      end
      3'd3: begin e1.rd = 1; e1.addr = up1; nrd = {16'h0, rd_mem(up1)}; nsp = up1; end
      3'd4: begin
        e1.wr = 1; e1.addr = sp_m; e1.wd = wd[31:16];
        e2.wr = 1; e2.addr = dn1;  e2.wd = wd[15:0];
        mem_m[sp_m] = wd[31:16]; mem_m[dn1] = wd[15:0];
        nsp = sp_m - 32'd2;
      end
      3'd5: begin
        e1.rd = 1; e1.addr = up1;
        e2.rd = 1; e2.addr = up2;
        nrd = {rd_mem(up2), rd_mem(up1)}; nsp = up2;
      end
      default: begin err = 1; nrd = 32'h0; end
    endcase
    er = blank(); er.vld = 1; er.err = err; er.rdata = nrd; er.sp = nsp;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    if (op == 3'd4 || op == 3'd5) exp_q.push_back(e2);
    exp_q.push_back(er);
    sp_m = nsp; rdata_m = nrd;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    nchk++; nfail++;
    $display("FAIL wait_idle: %0d expected cycles still pending, required 0", exp_q.size());
    exp_q.delete();
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    wait_idle();
    @(posedge clk); #1;
    plan(op, a, wd);
    in_valid = 1; in_op = op; in_addr = a; in_wdata = wd;
    @(posedge clk); #1;
    acc_cyc = cyc;
    // a competing request while busy must be ignored
    in_op = 3'd2; in_addr = ~a; in_wdata = ~wd;
    @(posedge clk); #1;
    in_valid = 0;
    wait_idle();
  endtask

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else begin e = blank(); e.rdy = 1; end
        chk("in_ready", in_ready, e.rdy);
        chk("mem_rd", mem_rd, e.rd);
        chk("mem_wr", mem_wr, e.wr);
        if (e.rd || e.wr) chk("mem_addr", mem_addr, e.addr);
        if (e.wr) chk("mem_wdata", mem_wdata, e.wd);
        chk("out_valid", out_valid, e.vld);
        if (e.vld) chk("out_err", out_err, e.err);
        chk("out_rdata", out_rdata, e.rdata);
        chk("sp", sp, e.sp);
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_wr) wr_log.push_back({mem_addr, mem_wdata});
        if (out_valid) vld_cyc = cyc;
        if (z_mem_wr) z_wr_addr = z_mem_addr;
        if (z_mem_rd) z_rd_addr = z_mem_addr;
      end
    end
  end

  initial begin : memory
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      mem_rdata = rd_mem(mem_addr);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    in_valid = 0; in_op = 3'd0; in_addr = 32'h0; in_wdata = 32'h0;
    z_wr_addr = 32'h1; z_rd_addr = 32'h1;
    #2 rst = 1;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_err", out_err, 0);
    chk("rst out_rdata", out_rdata, 32'h0);
    chk("rst sp", sp, SP_INIT);
    chk("rst mem_rd", mem_rd, 0);
    chk("rst mem_wr", mem_wr, 0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    sp_m = SP_INIT; rdata_m = 32'h0; chk_en = 1;

    wr_log.delete();
    do_op(3'd2, 32'h0, 32'h0000_1234);
    chk("push wr count", wr_log.size(), 1);
    chk("push wr addr", wr_log[0][47:16], 32'h000F_FFFF);
    chk("push wr data", wr_log[0][15:0], 32'h1234);
    chk("push sp", sp, 32'h000F_FFFE);
    chk("push latency", vld_cyc - acc_cyc + 1, 2);
    chk("wrap push addr", z_wr_addr, 32'h0);
    chk("wrap push sp", z_sp, 32'hFFFF_FFFF);

    do_op(3'd3, 32'h0, 32'h0);
    chk("pop rdata", out_rdata, 32'h0000_1234);
    chk("pop sp", sp, 32'h000F_FFFF);
    chk("wrap pop addr", z_rd_addr, 32'h0);
    chk("wrap pop sp", z_sp, 32'h0);

    wr_log.delete();
    do_op(3'd4, 32'h0, 32'hAAAA_5555);
    chk("push32 wr count", wr_log.size(), 2);
    chk("push32 wr0", {wr_log[0][47:16]}, 32'h000F_FFFF);
    chk("push32 wd0", wr_log[0][15:0], 32'hAAAA);
    chk("push32 wr1", {wr_log[1][47:16]}, 32'h000F_FFFE);
    chk("push32 wd1", wr_log[1][15:0], 32'h5555);
    chk("push32 sp", sp, 32'h000F_FFFD);
    chk("push32 latency", vld_cyc - acc_cyc + 1, 3);

    do_op(3'd5, 32'h0, 32'h0);
    chk("pop32 rdata", out_rdata, 32'hAAAA_5555);
    chk("pop32 sp", sp, 32'h000F_FFFF);
    chk("pop32 latency", vld_cyc - acc_cyc + 1, 3);

    do_op(3'd1, 32'h0000_0020, 32'h0000_BEEF);
    do_op(3'd0, 32'h0000_0020, 32'h0);
    chk("ldd rdata", out_rdata, 32'h0000_BEEF);
    do_op(3'd1, 32'h0000_0040, 32'hDEAD_0042);
    do_op(3'd0, 32'h0000_0040, 32'h0);
    chk("ldd upper ignored", out_rdata, 32'h0000_0042);
    do_op(3'd0, 32'h0000_1000, 32'h0);

    do_op(3'd7, 32'h0000_0020, 32'hFFFF_FFFF);
    chk("illegal rdata", out_rdata, 32'h0);
    chk("illegal sp", sp, 32'h000F_FFFF);
    do_op(3'd6, 32'h0000_0020, 32'h0);

    for (int i = 0; i < 6; i++) do_op(t_op[i], 32'h0, t_wd[i]);
    chk("table sp", sp, 32'h0010_0001);

    // reset in W1 of PUSH32 must abort without a response
    wait_idle();
    chk_en = 0;
    @(posedge clk); #1;
    in_valid = 1; in_op = 3'd4; in_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    in_valid = 0;
    chk("abort w0 mem_wr", mem_wr, 1);
    @(posedge clk); #1;
    chk("abort w1 mem_wr", mem_wr, 1);
    #2 rst = 1;
    #1;
    chk("abort mem_wr", mem_wr, 0);
    chk("abort out_valid", out_valid, 0);
    chk("abort sp", sp, SP_INIT);
    chk("abort in_ready", in_ready, 1);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post abort out_valid", out_valid, 0);
      chk("post abort mem_wr", mem_wr, 0);
    end
    mem_m[sp_m] = 16'hCAFE;
    sp_m = SP_INIT; rdata_m = 32'h0;
    chk_en = 1;

    do_op(3'd2, 32'h0, 32'h0000_5A5A);
    chk("recover sp", sp, 32'h000F_FFFE);
    wait_idle();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
